// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter -- round-robin arbiter for N requesters with a one-hot ring
// priority pointer. A grant is held until its owner drops req, then the ring
// advances one past the previous owner and a one-cycle turnaround follows.
//
// Optional build macro: RING_ARB_TIMEOUT_EN
//   defined   -> a grant is forcibly released after MAX_HOLD cycles, pulsing timeout
//   undefined -> no hold limit, timeout tied 0, hold counter not built
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req[N]     request vector, bit i held while requester i wants/owns the resource
//   gnt[N]     registered one-hot grant, zero when idle
//   gnt_valid  registered, 1 exactly when gnt != 0
//   gnt_id     registered binary owner index, keeps the last owner when idle
//   ptr[N]     registered one-hot ring pointer (highest priority next arbitration)
//   timeout    one-cycle pulse on a forced release
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr,
  output logic           timeout
);

  // Elaboration-time parameter sanity.
  if (N < 2 || IDW != $clog2(N) || MAX_HOLD < 2) begin : g_param_err
    $error("ring_rr_arbiter: bad parameters");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_d, ptr_d;
  logic           gnt_valid_d, timeout_d;
  logic [IDW-1:0] gnt_id_d;

  logic [IDW-1:0] ptr_idx, win_id, nxt_id;
  logic           force_rel;

  // Binary position of the one-hot ring pointer.
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < N; i++)
      if (ptr[i]) ptr_idx = IDW'(i);
  end

  // Circular scan from ptr upward. Iterating offsets high to low lets the
  // smallest offset with a set request win by being written last.
  always_comb begin
    win_id = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[(int'(ptr_idx) + j) % N]) win_id = IDW'((int'(ptr_idx) + j) % N);
    end
  end

  // Owner after which the ring resumes, wrapping N-1 -> 0.
  assign nxt_id = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

`ifdef RING_ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD);
  logic [HCW-1:0] hold_cnt;

  // Stays at zero through IDLE, so it is already cleared on the grant edge.
  always_ff @(posedge clk) begin
    if (rst)                                hold_cnt <= '0;
    else if (state_q == IDLE)               hold_cnt <= '0;
    else if (hold_cnt != HCW'(MAX_HOLD - 1)) hold_cnt <= hold_cnt + 1'b1;
  end

  assign force_rel = (state_q == BUSY) && req[gnt_id] &&
                     (hold_cnt == HCW'(MAX_HOLD - 1));
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt;
    gnt_valid_d = gnt_valid;
    gnt_id_d    = gnt_id;
    ptr_d       = ptr;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          gnt_d       = ONE << win_id;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_id;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Other requesters never preempt; only the owner's req (or the hold
        // limit) ends the grant.
        if (!req[gnt_id] || force_rel) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = ONE << nxt_id;
          timeout_d   = force_rel;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= ONE;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
      gnt_id    <= gnt_id_d;
      ptr       <= ptr_d;
      timeout   <= timeout_d;
    end
  end

endmodule
